dp_ctrl_seq: RTL
================

Name: dp_ctrl_seq

Overview:
- Control-side sequencer for the 5-stage SIMD data path.
- Holds a small program of per-cycle control words and issues one word per cycle to the data path: mux selects, PE opcodes, RF write enables and RF addresses.
- Throttles issue against the stream_in valid/ready handshake.
- Tracks which issued words produce a result through a latency-matched valid pipe, so stream_out is qualified by out_valid.

Parameters:
- NUM_STG, 5, number of data-path stages with mux/PE/RF (num_col-1).
- RF_AW, 3, RF address width (dwidth_RFadd).
- IMEM_DEPTH, 16, program words; power of two.
- PIPE_LAT, 4, cycles from control issue to a valid stream_out (PE_typeB/C/D register stages).
- ITER_W, 16, width of the iteration count.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- prog_we, in, 1, program write strobe; honoured only in IDLE.
- prog_addr, in, $clog2(IMEM_DEPTH), program write address.
- prog_data, in, INSTR_W, instr_t word.
- prog_len, in, $clog2(IMEM_DEPTH)+1, words per iteration; sampled at start.
- iter_cnt, in, ITER_W, iterations; sampled at start.
- start, in, 1, begin run; 1-cycle pulse; honoured only in IDLE.
- s_valid, in, 1, stream_in beat available.
- s_ready, out, 1, current word consumes stream_in this cycle.
- sel_mux4, out, 4*NUM_STG, per-stage mux selects.
- op, out, 2*NUM_STG, per-stage opcodes.
- wen_RF, out, NUM_STG, per-stage RF write enables.
- rd_addr_RF, out, RF_AW*NUM_STG, per-stage RF read addresses.
- wr_addr_RF, out, RF_AW*NUM_STG, per-stage RF write addresses.
- out_valid, out, 1, stream_out carries a result this cycle.
- busy, out, 1, high outside IDLE.
- done, out, 1, 1-cycle pulse at end of DRAIN.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, pc=0, iteration counter=0, valid pipe cleared. Program memory is not reset. Reset mid-run aborts immediately and leaves no done pulse.
- instr_t fields:
  - per stage: sel[3:0], op[1:0], wen, rd[RF_AW-1:0], wr[RF_AW-1:0];
  - cons: word waits for stream_in;
  - emit: word produces a stream_out result.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on start with prog_len!=0 and iter_cnt!=0. Otherwise start yields done the next cycle and stays in IDLE.
- RUN, word at pc is issuable when cons=0, or cons=1 and s_valid=1.
  - s_ready = RUN & cons, combinational.
  - Issue: the control outputs register the word's fields (1-cycle latency) and pc advances.
  - Stall: the control outputs keep their sel/op/addr but wen_RF is forced 0 (bubble); the valid pipe shifts in 0.
- Wrap: when pc==prog_len-1 is issued, pc->0 and the iteration counter increments. When the last iteration's last word issues, go to DRAIN.
- DRAIN:
  - wen_RF=0, s_ready=0;
  - count PIPE_LAT+1 cycles;
  - pulse done on the last DRAIN cycle, then go to IDLE.
- Valid pipe: PIPE_LAT+1 deep shift register, fed with emit&issue. out_valid is its tail, aligned with stream_out.
- prog_we while busy is dropped silently. prog_we and start in the same IDLE cycle: the write lands first and the run uses the new word.
- prog_len>IMEM_DEPTH is clamped to IMEM_DEPTH.

Optional Feature:
- Macro: DP_CTRL_SEQ_PERF_EN.
- Defined:
  - adds outputs perf_issue (32) and perf_stall (32);
  - counters clear on start, count issues and RUN stall cycles, saturate at all-ones, and hold after done;
  - async reset to 0.
- Undefined: no counters and no ports.

Decomposition:
- Package dp_ctrl_pkg holds:
  - constants NUM_STG, RF_AW, PIPE_LAT;
  - stage_ctrl_t (packed sel/op/wen/rd/wr);
  - instr_t (array of stage_ctrl_t plus cons, emit);
  - INSTR_W = $bits(instr_t);
  - state_t enum.
- One sub-module: dp_valid_pipe, a parameterised shift register with async active-low reset, reused for out_valid alignment.

Test Plan:
- Load 3 words (emit=1, cons=0), prog_len=3, iter_cnt=2, start -> 6 consecutive issues, pc 0,1,2,0,1,2; out_valid high for 6 cycles starting PIPE_LAT+1 cycles after the first issue; done is a single pulse.
- Word 1 has cons=1, s_valid held low 4 cycles -> s_ready=1, wen_RF=0 for 4 cycles, outputs otherwise frozen; issue on the first s_valid=1 cycle; out_valid shows a 4-cycle gap.
- start with iter_cnt=0 -> busy never rises; done pulses next cycle.
- prog_we to addr 2 during RUN -> memory unchanged; a re-run reproduces the original control sequence.
- rst_n low mid-RUN for 1 cycle -> all outputs 0 asynchronously; FSM IDLE; no done; the program survives and a subsequent run is correct.
- With DP_CTRL_SEQ_PERF_EN, 4-word program, 2 iterations, 3 stall cycles -> perf_issue=8, perf_stall=3.

Source files
------------

// File: rtl/dp_ctrl_pkg.sv
// Shared types and constants for the SIMD data-path control sequencer.
package dp_ctrl_pkg;
  localparam int NUM_STG    = 5;
  localparam int RF_AW      = 3;
  localparam int PIPE_LAT   = 4;
  localparam int IMEM_DEPTH = 16;
  localparam int ITER_W     = 16;
  localparam int PC_W       = $clog2(IMEM_DEPTH);
  localparam int DC_W       = $clog2(PIPE_LAT + 1);

  typedef struct packed {
    logic [3:0]       sel;
    logic [1:0]       op;
    logic             wen;
    logic [RF_AW-1:0] rd;
    logic [RF_AW-1:0] wr;
  } stage_ctrl_t;

  typedef struct packed {
    stage_ctrl_t [NUM_STG-1:0] stg;
    logic                      cons;
    logic                      emit;
  } instr_t;

  localparam int INSTR_W = $bits(instr_t);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [PC_W:0] MAX_LEN = (PC_W+1)'(IMEM_DEPTH);

  function automatic logic [PC_W:0] clamp_len(input logic [PC_W:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction
endpackage

// File: rtl/dp_valid_pipe.sv
// Valid-bit delay line with async active-low reset; output is STAGES+1 cycles behind input.
module dp_valid_pipe #(
  parameter int STAGES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_i,
  output logic vld_o
);
  logic [STAGES:0] vld_pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe_q <= '0;
    else        vld_pipe_q <= {vld_pipe_q[STAGES-1:0], vld_i};
  end

  assign vld_o = vld_pipe_q[STAGES];
endmodule

// File: rtl/dp_ctrl_seq.sv
// Program sequencer issuing one per-stage control word per cycle to the SIMD data path.
// Optional perf counters (perf_issue/perf_stall) are built when DP_CTRL_SEQ_PERF_EN is defined.
module dp_ctrl_seq
  import dp_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prog_we,
  input  logic [PC_W-1:0]          prog_addr,
  input  logic [INSTR_W-1:0]       prog_data,
  input  logic [PC_W:0]            prog_len,
  input  logic [ITER_W-1:0]        iter_cnt,
  input  logic                     start,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [4*NUM_STG-1:0]     sel_mux4,
  output logic [2*NUM_STG-1:0]     op,
  output logic [NUM_STG-1:0]       wen_RF,
  output logic [RF_AW*NUM_STG-1:0] rd_addr_RF,
  output logic [RF_AW*NUM_STG-1:0] wr_addr_RF,
`ifdef DP_CTRL_SEQ_PERF_EN
  output logic [31:0]              perf_issue,
  output logic [31:0]              perf_stall,
`endif
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done
);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(PIPE_LAT);

  instr_t                    imem [IMEM_DEPTH];
  instr_t                    cur;
  state_t                    state_q;
  logic [PC_W-1:0]           pc_q;
  logic [PC_W:0]             len_q;
  logic [ITER_W-1:0]         iter_q, niter_q;
  logic [DC_W-1:0]           dcnt_q;
  stage_ctrl_t [NUM_STG-1:0] ctrl_q;
  logic                      done_q;
  logic                      run, issue, last_word, last_iter;

  // Program memory is deliberately not reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (prog_we && state_q == IDLE) imem[prog_addr] <= prog_data;
  end

  assign cur       = imem[pc_q];
  assign run       = (state_q == RUN);
  assign issue     = run && (!cur.cons || s_valid);
  assign last_word = ({1'b0, pc_q} == len_q - 1'b1);
  assign last_iter = (iter_q == niter_q - 1'b1);
  assign s_ready   = run && cur.cons;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      iter_q  <= '0;
      niter_q <= '0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          pc_q    <= '0;
          iter_q  <= '0;
          len_q   <= clamp_len(prog_len);
          niter_q <= iter_cnt;
          if (prog_len != '0 && iter_cnt != '0) state_q <= RUN;
          else                                  done_q  <= 1'b1;
        end
        RUN: if (issue) begin
          if (last_word) begin
            pc_q   <= '0;
            iter_q <= iter_q + 1'b1;
            if (last_iter) begin
              state_q <= DRAIN;
              dcnt_q  <= '0;
            end
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
        DRAIN: begin
          // done is registered, so it is raised one edge early to land on the last DRAIN cycle.
          if (dcnt_q == DRAIN_LAST) begin
            state_q <= IDLE;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
            done_q <= (dcnt_q == DRAIN_LAST - 1'b1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Non-issue cycles become bubbles: fields hold, only the RF writes are killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (issue) begin
      ctrl_q <= cur.stg;
    end else begin
      for (int i = 0; i < NUM_STG; i++) ctrl_q[i].wen <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_STG; g++) begin : g_stg
    assign sel_mux4[4*g +: 4]         = ctrl_q[g].sel;
    assign op[2*g +: 2]               = ctrl_q[g].op;
    assign wen_RF[g]                  = ctrl_q[g].wen;
    assign rd_addr_RF[RF_AW*g +: RF_AW] = ctrl_q[g].rd;
    assign wr_addr_RF[RF_AW*g +: RF_AW] = ctrl_q[g].wr;
  end

  dp_valid_pipe #(.STAGES(PIPE_LAT)) u_vld (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (issue & cur.emit),
    .vld_o (out_valid)
  );

`ifdef DP_CTRL_SEQ_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else if (state_q == IDLE && start) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else if (run) begin
      if (issue && !(&perf_issue_q))  perf_issue_q <= perf_issue_q + 1'b1;
      if (!issue && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_issue = perf_issue_q;
  assign perf_stall = perf_stall_q;
`endif
endmodule
